regfile_read_port: RTL and testbench

Read-side controller for the 16x16 register array: accepts two-source read requests, drives the array's one-hot read enables for one cycle, captures both bitline buses, and returns the operand pair through a buffered valid/ready response port. It sits between the decode stage and the register array, which it treats as a passive bitcell store. Register 0 always reads as zero. An optional write-bypass path merges same-cycle writes into the returned data.

---
 rtl/wisc_rf_pkg.sv | 30 +++
 rtl/regfile_read_port_if.sv | 24 ++
 rtl/rf_resp_fifo.sv | 66 ++++++
 rtl/regfile_read_port.sv | 102 ++++++++++
 tb/tb_regfile_read_port.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_rf_pkg.sv
// Shared types and helpers for the 16x16 register-file read path.
package wisc_rf_pkg;

  localparam int WORD_W  = 16;
  localparam int NREG    = 16;
  localparam int REGID_W = 4;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [REGID_W-1:0] regid_t;

  // One buffered response: operand pair for rs1/rs2.
  typedef struct packed {
    word_t d1;
    word_t d2;
  } rsp_entry_t;

  // Register 0 is hard-wired to zero, so it never gets a read enable.
  function automatic logic [NREG-1:0] onehot16(input regid_t rs);
    logic [NREG-1:0] v;
    v = '0;
    if (rs != '0) v[rs] = 1'b1;
    return v;
  endfunction

  function automatic word_t merge_masked(input word_t old_val, input word_t new_val,
                                         input word_t mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/regfile_read_port_if.sv
// Request/response handshake bundle between decode and the register-file read port.
interface regfile_read_port_if;
  import wisc_rf_pkg::*;

  logic   req_valid;
  logic   req_ready;
  regid_t req_rs1;
  regid_t req_rs2;
  logic   rsp_valid;
  logic   rsp_ready;
  word_t  rsp_data1;
  word_t  rsp_data2;

  modport master (
    output req_valid, req_rs1, req_rs2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, rsp_ready,
    output req_ready, rsp_valid, rsp_data1, rsp_data2
  );

endinterface

// File: rtl/rf_resp_fifo.sv
// Circular response FIFO holding captured operand pairs; head is visible combinationally.
module rf_resp_fifo
  import wisc_rf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  rsp_entry_t       push_data,
  input  logic             pop,
  output rsp_entry_t       pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  rsp_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths stay circular.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    pop_data = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; stale contents are masked by the empty check above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/regfile_read_port.sv
// Register-file read controller: S1 enable stage, bitline capture, buffered response.
// Optional same-cycle write bypass is enabled by defining REGREAD_BYPASS_EN.
module regfile_read_port
  import wisc_rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  regfile_read_port_if.slave  rf,
  output logic [NREG-1:0]     rd_en1,
  output logic [NREG-1:0]     rd_en2,
  input  word_t               bitline1,
  input  word_t               bitline2,
  input  logic                wr_en,
  input  regid_t              wr_reg,
  input  word_t               wr_data,
  input  word_t               wr_mask
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             s1_valid_q, s1_valid_d;
  regid_t           s1_rs1_q, s1_rs1_d;
  regid_t           s1_rs2_q, s1_rs2_d;
  logic             accept;
  logic             pop;
  logic             push;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  word_t            d1, d2;
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;

  // Admission counts the entry still in S1, and a same-cycle pop frees a slot.
  always_comb begin
    pop          = !fifo_empty && rf.rsp_ready;
    occupancy    = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid_q) - (CNT_W + 1)'(pop);
    rf.req_ready = rst && (occupancy < (CNT_W + 1)'(DEPTH));
    accept       = rf.req_valid && rf.req_ready;
    s1_valid_d   = accept;
    s1_rs1_d     = accept ? rf.req_rs1 : s1_rs1_q;
    s1_rs2_d     = accept ? rf.req_rs2 : s1_rs2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
    end
  end

  always_comb begin
    rd_en1 = s1_valid_q ? onehot16(s1_rs1_q) : '0;
    rd_en2 = s1_valid_q ? onehot16(s1_rs2_q) : '0;
    d1     = (s1_rs1_q == '0) ? '0 : bitline1;
    d2     = (s1_rs2_q == '0) ? '0 : bitline2;
`ifdef REGREAD_BYPASS_EN
    // Bitlines carry the pre-write value; fold in the write landing at this edge.
    if (wr_en && (wr_reg == s1_rs1_q) && (s1_rs1_q != '0))
      d1 = merge_masked(bitline1, wr_data, wr_mask);
    if (wr_en && (wr_reg == s1_rs2_q) && (s1_rs2_q != '0))
      d2 = merge_masked(bitline2, wr_data, wr_mask);
`endif
    push          = s1_valid_q && !fifo_full;
    push_entry.d1 = d1;
    push_entry.d2 = d2;
  end

`ifndef REGREAD_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_reg, wr_data, wr_mask};
`endif

  rf_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rf.rsp_valid = !fifo_empty;
    rf.rsp_data1 = head_entry.d1;
    rf.rsp_data2 = head_entry.d2;
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Scoreboard bench for regfile_read_port with a behavioural 16x16 register array.
module tb_regfile_read_port;
  import wisc_rf_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NREG-1:0]  rd_en1, rd_en2;
  word_t            bitline1, bitline2;
  logic             wr_en = 1'b0;
  regid_t           wr_reg = '0;
  word_t            wr_data = '0;
  word_t            wr_mask = '0;
  logic             force_ones = 1'b0;
  word_t            arr [NREG];

  int               checks = 0;
  int               failures = 0;
  int               pops = 0;
  logic [31:0]      exp_q [$];

  regfile_read_port_if rf_if ();

  regfile_read_port #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rf       (rf_if),
    .rd_en1   (rd_en1),
    .rd_en2   (rd_en2),
    .bitline1 (bitline1),
    .bitline2 (bitline2),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask)
  );

  always #5 clk = ~clk;

  // Array model: writes commit at the edge, reads follow the one-hot enables.
  always @(posedge clk) begin
    if (wr_en) arr[wr_reg] <= (arr[wr_reg] & ~wr_mask) | (wr_data & wr_mask);
  end

  always_comb begin
    bitline1 = 16'h0000;
    bitline2 = 16'h0000;
    for (int i = 0; i < NREG; i++) begin
      if (rd_en1[i]) bitline1 = arr[i];
      if (rd_en2[i]) bitline2 = arr[i];
    end
    if (force_ones) begin
      bitline1 = 16'hFFFF;
      bitline2 = 16'hFFFF;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a response.
  always @(negedge clk) begin
    if (rst) begin
      chk("rd_en1_onehot", 32'(($countones(rd_en1) <= 1)), 32'd1);
      chk("rd_en2_onehot", 32'(($countones(rd_en2) <= 1)), 32'd1);
      if (rf_if.rsp_valid && rf_if.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=%h required=none",
                   {rf_if.rsp_data1, rf_if.rsp_data2});
        end else begin
          chk("rsp_data", {rf_if.rsp_data1, rf_if.rsp_data2}, exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input regid_t r, input word_t d);
    wr_en = 1'b1; wr_reg = r; wr_data = d; wr_mask = 16'hFFFF;
    cycles(1);
    wr_en = 1'b0;
  endtask

  // Offers a request until accepted; leaves req_valid high for back-to-back use.
  task automatic send(input regid_t a, input regid_t b, input word_t e1, input word_t e2,
                      output int waits);
    logic acc;
    rf_if.req_rs1 = a;
    rf_if.req_rs2 = b;
    rf_if.req_valid = 1'b1;
    waits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = rf_if.req_ready;
      if (acc) exp_q.push_back({e1, e2});
      @(posedge clk);
      #1;
      if (acc) return;
      waits++;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=no_accept required=accept rs1=%0d", a);
  endtask

  task automatic idle();
    rf_if.req_valid = 1'b0;
  endtask

  initial begin
    int w;
    word_t byp_exp;
    int pops_before;
    logic [3:0] n;
    rf_if.req_valid = 1'b0;
    rf_if.req_rs1   = '0;
    rf_if.req_rs2   = '0;
    rf_if.rsp_ready = 1'b1;
    #2;
    chk("rst_req_ready", 32'(rf_if.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rf_if.rsp_valid), 32'd0);
    chk("rst_rd_en", {rd_en1, rd_en2}, 32'h0);
    chk("rst_rsp_data", {rf_if.rsp_data1, rf_if.rsp_data2}, 32'h0);
    for (int i = 0; i < NREG; i++) begin
      n = 4'(i);
      wr(regid_t'(i), {n, n, n, n});
    end
    wr(4'd3, 16'h1234);
    wr(4'd5, 16'hBEEF);
    wr(4'd7, 16'h00FF);
    rst = 1'b1;
    #1;
    chk("post_rst_req_ready", 32'(rf_if.req_ready), 32'd1);

    // Basic latency: enables in N+1, response in N+2.
    send(4'd3, 4'd5, 16'h1234, 16'hBEEF, w);
    idle();
    chk("lat_rd_en1", 32'(rd_en1), 32'h0008);
    chk("lat_rd_en2", 32'(rd_en2), 32'h0020);
    chk("lat_n1_rsp_valid", 32'(rf_if.rsp_valid), 32'd0);
    cycles(1);
    chk("lat_n2_rsp_valid", 32'(rf_if.rsp_valid), 32'd1);
    cycles(3);

    // Register 0 reads zero and never raises an enable.
    force_ones = 1'b1;
    send(4'd0, 4'd0, 16'h0000, 16'h0000, w);
    idle();
    chk("r0_rd_en", {rd_en1, rd_en2}, 32'h0);
    cycles(3);
    force_ones = 1'b0;

    // Same-cycle write to r7 during S1.
`ifdef REGREAD_BYPASS_EN
    byp_exp = 16'hABFF;
`else
    byp_exp = 16'h00FF;
`endif
    send(4'd7, 4'd0, byp_exp, 16'h0000, w);
    idle();
    wr_en = 1'b1; wr_reg = 4'd7; wr_data = 16'hAB00; wr_mask = 16'hFF00;
    cycles(1);
    wr_en = 1'b0;
    cycles(3);

    // Stalled consumer: two accepted, then backpressure with a stable head.
    rf_if.rsp_ready = 1'b0;
    send(4'd1, 4'd2, 16'h1111, 16'h2222, w);
    send(4'd4, 4'd6, 16'h4444, 16'h6666, w);
    rf_if.req_rs1 = 4'd8;
    rf_if.req_rs2 = 4'd9;
    cycles(2);
    @(negedge clk);
    chk("stall_req_ready", 32'(rf_if.req_ready), 32'd0);
    chk("stall_head_a", {rf_if.rsp_data1, rf_if.rsp_data2}, 32'h11112222);
    cycles(2);
    @(negedge clk);
    chk("stall_req_ready_b", 32'(rf_if.req_ready), 32'd0);
    chk("stall_head_b", {rf_if.rsp_data1, rf_if.rsp_data2}, 32'h11112222);
    chk("stall_rsp_valid", 32'(rf_if.rsp_valid), 32'd1);
    cycles(1);
    rf_if.rsp_ready = 1'b1;
    send(4'd8, 4'd9, 16'h8888, 16'h9999, w);
    send(4'd10, 4'd11, 16'hAAAA, 16'hBBBB, w);
    idle();
    cycles(4);

    // Back-to-back: every request accepted on first offer, one response per cycle.
    pops_before = pops;
    send(4'd12, 4'd13, 16'hCCCC, 16'hDDDD, w);
    send(4'd14, 4'd15, 16'hEEEE, 16'hFFFF, w);
    chk("b2b_wait_1", 32'(w), 32'd0);
    send(4'd1, 4'd4, 16'h1111, 16'h4444, w);
    chk("b2b_wait_2", 32'(w), 32'd0);
    send(4'd2, 4'd6, 16'h2222, 16'h6666, w);
    chk("b2b_wait_3", 32'(w), 32'd0);
    send(4'd8, 4'd9, 16'h8888, 16'h9999, w);
    chk("b2b_wait_4", 32'(w), 32'd0);
    send(4'd3, 4'd5, 16'h1234, 16'hBEEF, w);
    chk("b2b_wait_5", 32'(w), 32'd0);
    idle();
    cycles(2);
    chk("b2b_pop_count", 32'(pops - pops_before), 32'd6);
    cycles(2);

    // Reset with one response buffered and one request in S1.
    rf_if.rsp_ready = 1'b0;
    send(4'd1, 4'd2, 16'h1111, 16'h2222, w);
    send(4'd4, 4'd6, 16'h4444, 16'h6666, w);
    idle();
    chk("pre_rst_buffered", 32'(rf_if.rsp_valid), 32'd1);
    chk("pre_rst_inflight", 32'(rd_en1), 32'h0010);
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_rsp_valid", 32'(rf_if.rsp_valid), 32'd0);
    chk("mid_rst_rd_en", {rd_en1, rd_en2}, 32'h0);
    chk("mid_rst_rsp_data", {rf_if.rsp_data1, rf_if.rsp_data2}, 32'h0);
    chk("mid_rst_req_ready", 32'(rf_if.req_ready), 32'd0);
    rf_if.rsp_ready = 1'b1;
    cycles(2);
    rst = 1'b1;
    cycles(4);
    chk("post_rst_no_stale", 32'(rf_if.rsp_valid), 32'd0);
    send(4'd3, 4'd5, 16'h1234, 16'hBEEF, w);
    idle();

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycles(1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
